// File: rtl/uart_pkg.sv
// Shared UART definitions: frame shape, FSM state encoding and baud divider helper.
// Used by both the transmitter and the receiver.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // Truncating divide; every bit period of the frame uses this many clocks.
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-wide valid/ready write port feeding the UART transmit FIFO.
interface uart_tx_fifo_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with first-word fall-through read; depth must be a power of two >= 2.
module uart_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk_50mhz,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_50mhz) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_top.sv
// Buffered 8N1 UART transmitter: write port fills a byte FIFO, a bit-period FSM
// drains it one frame at a time onto a registered, idle-high tx line.
module uart_tx_fifo_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk_50mhz,
  input  logic                            reset,
  uart_tx_fifo_if.slave                   wr,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  uart_state_t      state;
  uart_state_t      state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [2:0]       idx;
  logic [2:0]       idx_nx;
  logic [7:0]       shift;
  logic [7:0]       shift_nx;
  logic             tx_nx;
  logic             bit_end;

  logic             push;
  logic             pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;

  assign wr.tx_ready = !fifo_full;
  assign push        = wr.tx_valid && !fifo_full;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .push      (push),
    .din       (wr.tx_data),
    .pop       (pop),
    .dout      (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bit_end = (cnt == CNT_W'(CPB - 1));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shift_nx = shift;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_nx = fifo_dout;
          cnt_nx   = '0;
          state_nx = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = ST_DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_nx   = '0;
          shift_nx = {1'b0, shift[7:1]};
          idx_nx   = idx + 3'd1;
          if (idx == 3'(DATA_BITS - 1)) begin
            state_nx = ST_STOP;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_nx = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_nx = fifo_dout;
            state_nx = ST_START;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Line level is derived from the next state so tx is a clean flop output.
  always_comb begin
    tx_nx = 1'b1;
    case (state_nx)
      ST_START: tx_nx = 1'b0;
      ST_DATA:  tx_nx = shift_nx[0];
      default:  tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      tx    <= tx_nx;
      busy  <= (state_nx != ST_IDLE);
    end
  end

  always_ff @(posedge clk_50mhz) begin
    shift <= shift_nx;
  end

endmodule

// File: tb/tb_uart_tx_fifo_top.sv
// Randomised bench for uart_tx_fifo_top against a frame-timeline model plus a line decoder.
module tb_uart_tx_fifo_top;

  localparam int CLK_FREQ  = 1600000;
  localparam int BAUD_RATE = 100000;
  localparam int DEPTH     = 8;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int FRAME     = 10 * CPB;

  logic       clk_50mhz = 1'b0;
  logic       reset;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;

  uart_tx_fifo_if wr();

  uart_tx_fifo_top #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_50mhz  (clk_50mhz),
    .reset      (reset),
    .wr         (wr),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: queue of waiting bytes and a frame timeline (cycles since start edge).
  logic [7:0] mq[$];
  logic [7:0] sent_q[$];
  bit         act;
  int         t;
  logic [7:0] cur;
  bit         last_push;

  // Independent decoder watching the DUT line.
  bit         dec_on;
  int         dec_t;
  logic [7:0] dec_byte;

  function automatic logic exp_tx();
    int k;
    if (!act) return 1'b1;
    k = t / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return cur[k-1];
    return 1'b1;
  endfunction

  task automatic model_clear();
    mq.delete();
    sent_q.delete();
    act    = 0;
    t      = 0;
    dec_on = 0;
    dec_t  = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    int pre;
    pre       = mq.size();
    last_push = v && (pre != DEPTH);
    if (act) begin
      t++;
      if (t == FRAME) act = 0;
    end
    if (!act && pre > 0) begin
      cur = mq.pop_front();
      act = 1;
      t   = 0;
    end
    if (last_push) begin
      mq.push_back(d);
      sent_q.push_back(d);
    end
  endtask

  task automatic check_outputs();
    chk("tx", tx, exp_tx());
    chk("busy", busy, act);
    chk("fifo_count", fifo_count, mq.size());
    chk("tx_ready", wr.tx_ready, mq.size() != DEPTH);
  endtask

  task automatic decode();
    int k;
    if (!dec_on) begin
      if (tx === 1'b0) begin
        dec_on = 1;
        dec_t  = 0;
      end
    end else begin
      dec_t++;
    end
    if (dec_on && (dec_t % CPB) == CPB / 2) begin
      k = dec_t / CPB;
      if (k == 0) begin
        chk("start_bit", tx, 1'b0);
      end else if (k <= 8) begin
        dec_byte[k-1] = tx;
      end else begin
        chk("stop_bit", tx, 1'b1);
        chk("frame_expected", sent_q.size() != 0, 1'b1);
        if (sent_q.size() != 0) chk("rx_byte", dec_byte, sent_q.pop_front());
        dec_on = 0;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    @(negedge clk_50mhz);
    wr.tx_valid = v;
    wr.tx_data  = d;
    @(posedge clk_50mhz);
    model_step(v, d);
    #1;
    check_outputs();
    decode();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 8'($urandom));
  endtask

  task automatic send(input logic [7:0] d);
    for (int n = 0; n < 2 * FRAME; n++) begin
      cycle(1'b1, d);
      if (last_push) return;
    end
    chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    int bound;
    bound = (mq.size() + 2) * FRAME + 20;
    for (int n = 0; n < bound; n++) begin
      if (!act && mq.size() == 0 && !dec_on) begin
        idle(5);
        return;
      end
      cycle(1'b0, 8'($urandom));
    end
    chk("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk_50mhz);
    reset       = 1'b1;
    wr.tx_valid = 1'b0;
    model_clear();
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", wr.tx_ready, 1'b1);
    @(posedge clk_50mhz);
    #1;
    chk("rst_hold_tx", tx, 1'b1);
    chk("rst_hold_count", fifo_count, 0);
    @(negedge clk_50mhz);
    reset = 1'b0;
  endtask

  initial begin
    int accepted;
    int bound;
    reset       = 1'b1;
    wr.tx_valid = 1'b0;
    wr.tx_data  = 8'h00;
    model_clear();
    do_reset();
    idle(5);

    // Single 0x55 frame.
    send(8'h55);
    drain();

    // Three bytes on consecutive cycles, sent back to back.
    cycle(1'b1, 8'h01);
    cycle(1'b1, 8'h02);
    cycle(1'b1, 8'h03);
    drain();

    // Continuous writes with data changing every cycle, including stalled ones.
    accepted = 0;
    for (int n = 0; n < 20 * FRAME && accepted < 12; n++) begin
      cycle(1'b1, 8'($urandom));
      if (last_push) accepted++;
    end
    chk("burst_accepted", accepted, 12);
    drain();

    // Reset during data bit 3 of 0xF0 with four bytes waiting.
    send(8'hF0);
    for (int i = 0; i < 4; i++) send(8'($urandom));
    bound = 0;
    while (!(act && t == 4 * CPB + CPB / 2) && bound < 2 * FRAME) begin
      cycle(1'b0, 8'h00);
      bound++;
    end
    chk("pre_reset_count", fifo_count, 4);
    chk("pre_reset_busy", busy, 1'b1);
    do_reset();
    idle(2 * FRAME);

    // Random traffic with bursty valid.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom % 6) == 0, 8'($urandom));
    end
    drain();
    chk("all_bytes_sent", sent_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
